// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the RV32M iterative multiply/divide unit:
//   FSM state type, M-extension funct7 match value, funct3 op encodings
//   and the default datapath width.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int unsigned MULDIV_XLEN = 32;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational radix-2 iteration on unsigned magnitudes.
//     is_div_i = 0 : shift-add multiply step. {hi,lo} is the running product,
//                    lo[0] is the current multiplier bit, opnd_i the
//                    multiplicand.
//     is_div_i = 1 : restoring divide step. hi is the partial remainder,
//                    lo shifts the dividend out at the top and collects
//                    quotient bits at the bottom, opnd_i is the divisor.
// Ports
//   is_div_i  in   select divide (1) or multiply (0) step
//   hi_i/lo_i in   current upper/lower working registers
//   opnd_i    in   multiplicand or divisor magnitude
//   hi_o/lo_o out  working registers after this step
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);

        // 33-bit partial remainder; after a successful subtract the result
        // is below the divisor, so the low XLEN bits of the difference are exact.
        shifted = {hi_i, lo_i[XLEN-1]};
        fits    = (shifted >= {1'b0, opnd_i});
        diff    = shifted[XLEN-1:0] - opnd_i;

        if (is_div_i) begin
            hi_o = fits ? diff : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], fits};
        end else begin
            hi_o = add_sum[XLEN:1];
            lo_o = {add_sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
//   Iterative RV32M multiply/divide unit in the EX stage. Accepts an M-op
//   from ID/EX, stalls the front of the pipeline while iterating
//   (32 radix-2 steps), then presents the result for one cycle.
//   Divide-by-zero and signed overflow complete without iterating.
// Ports
//   clk_i      in   clock, rising edge
//   rst_n_i    in   asynchronous active-low reset
//   req_i      in   ID/EX holds a valid R-type op
//   funct_i    in   {funct7, funct3}
//   RS1data_i  in   forwarded rs1 value
//   RS2data_i  in   forwarded rs2 value
//   RDaddr_i   in   destination register
//   flush_i    in   squash the op in flight
//   stall_o    out  hold PC, IF/ID and ID/EX
//   done_o     out  one-cycle pulse, result_o/RDaddr_o valid
//   result_o   out  result of the completed op (held until the next one)
//   RDaddr_o   out  destination of the completed op (held)
// -----------------------------------------------------------------------------
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      RDaddr_o
);

    localparam int unsigned   CNT_W   = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e    state_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  opnd_q;
    logic [2:0]       f3_q;
    logic             neg_q;   // negate product / quotient
    logic             rneg_q;  // negate remainder
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rdout_q;

    // Decode of the incoming op
    logic            is_m_op;
    logic            go;
    logic [2:0]      f3;
    logic            in_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        f3       = funct_i[2:0];
        is_m_op  = (funct_i[9:3] == MULDIV_FUNCT7);
        go       = rst_n_i & req_i & is_m_op & ~flush_i & (state_q == IDLE);
        in_div   = f3[2];
        a_signed = (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
        b_signed = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
        a_neg    = a_signed & RS1data_i[XLEN-1];
        b_neg    = b_signed & RS2data_i[XLEN-1];
        a_mag    = a_neg ? (~RS1data_i + 1'b1) : RS1data_i;
        b_mag    = b_neg ? (~RS2data_i + 1'b1) : RS2data_i;
        div_zero = in_div && (RS2data_i == '0);
        div_ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
                   (RS1data_i == MIN_NEG) && (RS2data_i == '1);

        // f3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = f3[1] ? RS1data_i : '1;
        end else begin
            special_res = f3[1] ? '0 : MIN_NEG;
        end
    end

    // Iteration datapath
    logic [XLEN-1:0] st_hi;
    logic [XLEN-1:0] st_lo;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (f3_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (st_hi),
        .lo_o     (st_lo)
    );

    // Sign fix-up applied to the output of the final step
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fix = neg_q  ? (~{st_hi, st_lo} + 1'b1) : {st_hi, st_lo};
        quot_fix = neg_q  ? (~st_lo + 1'b1)          : st_lo;
        rem_fix  = rneg_q ? (~st_hi + 1'b1)          : st_hi;

        if (!f3_q[2]) begin
            final_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            final_res = f3_q[1] ? rem_fix : quot_fix;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rdout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        f3_q    <= f3;
                        rd_q    <= RDaddr_i;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        count_q <= '0;
                        hi_q    <= '0;
                        // Multiply iterates over the multiplier in lo;
                        // divide shifts the dividend out of lo.
                        lo_q    <= in_div ? a_mag : b_mag;
                        opnd_q  <= in_div ? b_mag : a_mag;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            rdout_q  <= RDaddr_i;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        hi_q    <= st_hi;
                        lo_q    <= st_lo;
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_LAST) begin
                            result_q <= final_res;
                            rdout_q  <= rd_q;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_o  = go | ((state_q == BUSY) & ~flush_i);
        done_o   = (state_q == DONE) & ~flush_i;
        result_o = result_q;
        RDaddr_o = rdout_q;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes the ID/EX pipeline-register outputs (operands, funct, destination) and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it computes, it stalls the front of the pipeline, then presents a one-cycle result toward EX/MEM. It sits beside the ALU, behind the forwarding muxes.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req_i  in  1  ID/EX holds a valid R-type op (ALUOp == 2'b10, RegWrite == 1)
- funct_i  in  10  {funct7, funct3} from ID/EX; M-op when funct_i[9:3] == 7'b0000001
- RS1data_i  in  32  forwarded rs1 value
- RS2data_i  in  32  forwarded rs2 value
- RDaddr_i  in  5  destination register
- flush_i  in  1  abort current op (branch/exception squash)
- stall_o  out  1  hold PC, IF/ID, ID/EX (ID/EX start_i deasserted)
- done_o  out  1  one-cycle pulse: result_o/RDaddr_o valid
- result_o  out  32  result
- RDaddr_o  out  5  destination of completed op

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state IDLE; stall_o = 0, done_o = 0, result_o = 0, RDaddr_o = 0, counter = 0.
- IDLE, go = req_i & M-op & ~flush_i:
  - latch operands, funct3, RDaddr_i;
  - stall_o = go (combinational, same cycle).
  - Special cases go directly to DONE; all other ops go to BUSY with count = 0.
- Special cases (no iteration):
  - DIV/DIVU/REM/REMU with RS2 == 0: quotient = 32'hFFFF_FFFF, remainder = RS1.
  - DIV/REM with RS1 == 32'h8000_0000 and RS2 == 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0.
- BUSY: one radix-2 step per cycle, 32 steps (count 0..31); stall_o = 1; after count == 31, go to DONE.
- DONE: done_o = 1; result_o and RDaddr_o hold the final values; stall_o = 0 so ID/EX advances; next state IDLE. req_i is ignored in DONE, so the same instruction is never re-accepted.
- flush_i in BUSY or DONE:
  - next state IDLE;
  - done_o is suppressed when flush_i is seen in the same cycle;
  - stall_o drops in the same cycle.
- Arithmetic and width rules:
  - Multiply: shift-add on 32-bit magnitudes into a 64-bit product; negate if operand signs differ.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - MUL returns product[31:0]; MULH* return product[63:32].
  - Divide: restoring on magnitudes with a 33-bit partial remainder.
  - Sign fix-up: quotient negated if sign(RS1) ^ sign(RS2) (signed ops only); remainder takes the sign of RS1.
- result_o and RDaddr_o hold their last values outside DONE. Consumers qualify them with done_o.

## Timing
- Accept at edge T (IDLE, go = 1).
- Normal op: BUSY for cycles T+1..T+32; DONE in cycle T+33; back to IDLE at T+34. stall_o is high in cycles T..T+32.
- Special case: DONE in cycle T+1; stall_o is high in cycle T only.
- Back-to-back M-ops: the second is accepted in the IDLE cycle after DONE, with no gap beyond DONE.
- Async reset mid-BUSY: outputs go to reset values immediately; no done_o is issued for the aborted op.

## Structure
- muldiv_pkg:
  - state enum {IDLE, BUSY, DONE};
  - MULDIV_FUNCT7 = 7'b0000001;
  - funct3 constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - XLEN default.
- One sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract, selected by op class).
- ex_muldiv owns the FSM, counter, operand/sign registers and fix-up.

## Test plan
- MUL 7 × −3 (0xFFFF_FFFD): stall_o high cycles T..T+32; done_o at T+33 with result 0xFFFF_FFEB; RDaddr_o echoes the input.
- MULH/MULHSU/MULHU with 0x8000_0000 × 0xFFFF_FFFF → 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFF_FFFF and REM 5/0 → 5, each with done_o at T+1; DIV 0x8000_0000 / −1 → 0x8000_0000 at T+1.
- flush_i asserted at T+10 → state IDLE at T+11, no done_o, stall_o low from T+10. Separately, rst_n_i low at T+5 → all outputs zero at once.
- Non-M R-type (funct7 = 0) with req_i = 1 → never accepted, stall_o stays 0. Two consecutive MULs → second accepted in cycle T+34, done_o at T+67.
